// File: rtl/pipe_pkg.sv
// Shared pipeline types for the LEGv8 5-stage core: decoded control word,
// zero-register index and the RAW match helper used by hazard detection.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       branch;
        logic       uses_ra1;
        logic       uses_ra2;
    } ctrl_t;

    localparam logic [4:0] XZR         = 5'd31;
    localparam ctrl_t      CTRL_BUBBLE = '0;

    // An in-flight producer matches the ID consumer only on a real register write.
    function automatic logic raw_match(
        input logic       v,
        input logic       reg_write,
        input logic [4:0] wa,
        input logic [4:0] ra1,
        input logic [4:0] ra2,
        input logic       uses_ra1,
        input logic       uses_ra2
    );
        return v & reg_write & (wa != XZR) &
               (((wa == ra1) & uses_ra1) | ((wa == ra2) & uses_ra2));
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational stall decision for the ID/EX boundary.
// ID_EX_FWD_EN selects load-use-only stalling; otherwise any EX/MEM RAW stalls.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       reset_n,
    input  logic       id_valid,
    input  logic       flush_i,
    input  logic [4:0] id_ra1,
    input  logic [4:0] id_ra2,
    input  ctrl_t      id_ctrl,
    input  logic       ex_valid,
    input  ctrl_t      ex_ctrl,
    input  logic [4:0] ex_wa,
    input  logic       mem_valid,
    input  ctrl_t      mem_ctrl,
    input  logic [4:0] mem_wa,
    output logic       stall
);

    logic ex_hit;
    logic mem_hit;
    logic hazard;

    assign ex_hit  = raw_match(ex_valid, ex_ctrl.reg_write, ex_wa, id_ra1, id_ra2,
                               id_ctrl.uses_ra1, id_ctrl.uses_ra2);
    assign mem_hit = raw_match(mem_valid, mem_ctrl.reg_write, mem_wa, id_ra1, id_ra2,
                               id_ctrl.uses_ra1, id_ctrl.uses_ra2);

`ifdef ID_EX_FWD_EN
    // Only a load in EX cannot be covered by forwarding.
    assign hazard = ex_hit & ex_ctrl.mem_read;
`else
    assign hazard = ex_hit | mem_hit;
`endif

    // Flush wins over stall; nothing stalls while held in reset.
    assign stall = reset_n & id_valid & ~flush_i & hazard;

    logic unused_ok;
    assign unused_ok = &{1'b0, id_ctrl, ex_ctrl, mem_ctrl, mem_hit};

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with RAW stall generation and bubble insertion.
// Define ID_EX_FWD_EN to enable MEM/WB operand forwarding (load-use-only stalls).
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int N     = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [N-1:0]     id_rd1,
    input  logic [N-1:0]     id_rd2,
    input  logic [4:0]       id_ra1,
    input  logic [4:0]       id_ra2,
    input  logic [4:0]       id_wa,
    input  logic [N-1:0]     id_imm,
    input  logic [N-1:0]     id_pc,
    input  ctrl_t            id_ctrl,
    input  logic             flush_i,
    input  logic             mem_valid,
    input  ctrl_t            mem_ctrl,
    input  logic [4:0]       mem_wa,
    input  logic [N-1:0]     mem_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_wa,
    input  logic [N-1:0]     wb_data,
    output logic             ex_valid,
    output logic [N-1:0]     ex_opa,
    output logic [N-1:0]     ex_opb,
    output logic [4:0]       ex_wa,
    output logic [N-1:0]     ex_imm,
    output logic [N-1:0]     ex_pc,
    output ctrl_t            ex_ctrl,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [N-1:0] ex_rd1;
    logic [N-1:0] ex_rd2;
    logic         capture;

    hazard_detect u_hazard (
        .reset_n   (reset_n),
        .id_valid  (id_valid),
        .flush_i   (flush_i),
        .id_ra1    (id_ra1),
        .id_ra2    (id_ra2),
        .id_ctrl   (id_ctrl),
        .ex_valid  (ex_valid),
        .ex_ctrl   (ex_ctrl),
        .ex_wa     (ex_wa),
        .mem_valid (mem_valid),
        .mem_ctrl  (mem_ctrl),
        .mem_wa    (mem_wa),
        .stall     (stall_o)
    );

    assign capture = id_valid & ~flush_i & ~stall_o;

    // Bubbles clear valid/control only; data fields hold their last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= CTRL_BUBBLE;
            ex_wa     <= '0;
            ex_rd1    <= '0;
            ex_rd2    <= '0;
            ex_imm    <= '0;
            ex_pc     <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall_o && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (capture) begin
                ex_valid <= 1'b1;
                ex_ctrl  <= id_ctrl;
                ex_wa    <= id_wa;
                ex_rd1   <= id_rd1;
                ex_rd2   <= id_rd2;
                ex_imm   <= id_imm;
                ex_pc    <= id_pc;
            end else begin
                ex_valid <= 1'b0;
                ex_ctrl  <= CTRL_BUBBLE;
            end
        end
    end

`ifdef ID_EX_FWD_EN
    logic [4:0] ex_ra1;
    logic [4:0] ex_ra2;
    logic       mem_fa, mem_fb, wb_fa, wb_fb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ra1 <= '0;
            ex_ra2 <= '0;
        end else if (capture) begin
            ex_ra1 <= id_ra1;
            ex_ra2 <= id_ra2;
        end
    end

    assign mem_fa = mem_valid & mem_ctrl.reg_write & (mem_wa != XZR) & (mem_wa == ex_ra1);
    assign mem_fb = mem_valid & mem_ctrl.reg_write & (mem_wa != XZR) & (mem_wa == ex_ra2);
    assign wb_fa  = wb_reg_write & (wb_wa != XZR) & (wb_wa == ex_ra1);
    assign wb_fb  = wb_reg_write & (wb_wa != XZR) & (wb_wa == ex_ra2);

    // MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        ex_opa = ex_rd1;
        if (mem_fa)     ex_opa = mem_result;
        else if (wb_fa) ex_opa = wb_data;
        ex_opb = ex_rd2;
        if (mem_fb)     ex_opb = mem_result;
        else if (wb_fb) ex_opb = wb_data;
    end
`else
    assign ex_opa = ex_rd1;
    assign ex_opb = ex_rd2;

    logic unused_ok;
    assign unused_ok = &{1'b0, mem_result, wb_reg_write, wb_wa, wb_data};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected EX captures,
// a monitor pops and compares whenever ex_valid is presented.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int N     = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             id_valid;
    logic [N-1:0]     id_rd1, id_rd2, id_imm, id_pc;
    logic [4:0]       id_ra1, id_ra2, id_wa;
    ctrl_t            id_ctrl;
    logic             flush_i;
    logic             mem_valid;
    ctrl_t            mem_ctrl;
    logic [4:0]       mem_wa;
    logic [N-1:0]     mem_result;
    logic             wb_reg_write;
    logic [4:0]       wb_wa;
    logic [N-1:0]     wb_data;
    logic             ex_valid;
    logic [N-1:0]     ex_opa, ex_opb, ex_imm, ex_pc;
    logic [4:0]       ex_wa;
    ctrl_t            ex_ctrl;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt;

    id_ex_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ra1(id_ra1), .id_ra2(id_ra2),
        .id_wa(id_wa), .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .flush_i(flush_i), .mem_valid(mem_valid), .mem_ctrl(mem_ctrl),
        .mem_wa(mem_wa), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
        .wb_wa(wb_wa), .wb_data(wb_data), .ex_valid(ex_valid), .ex_opa(ex_opa),
        .ex_opb(ex_opb), .ex_wa(ex_wa), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl), .stall_o(stall_o), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [N-1:0] opa, opb, pc;
        logic [4:0]   wa;
        ctrl_t        ctrl;
    } exp_t;

    exp_t  q[$];
    int    checks   = 0;
    int    failures = 0;
    int    exp_cnt  = 0;
    ctrl_t c_add, c_ldur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] opa, input logic [N-1:0] opb, input logic [4:0] wa,
                        input logic [N-1:0] pc, input ctrl_t c);
        exp_t e;
        e.opa = opa; e.opb = opb; e.wa = wa; e.pc = pc; e.ctrl = c;
        q.push_back(e);
    endtask

    task automatic id_set(input logic v, input ctrl_t c, input logic [4:0] ra1, input logic [4:0] ra2,
                          input logic [4:0] wa, input logic [N-1:0] rd1, input logic [N-1:0] rd2,
                          input logic [N-1:0] pc);
        id_valid = v; id_ctrl = c; id_ra1 = ra1; id_ra2 = ra2; id_wa = wa;
        id_rd1 = rd1; id_rd2 = rd2; id_pc = pc; id_imm = pc + 64'h1000;
    endtask

    task automatic id_idle();
        id_set(1'b0, '0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
    endtask

    task automatic mem_set(input logic v, input ctrl_t c, input logic [4:0] wa, input logic [N-1:0] r);
        mem_valid = v; mem_ctrl = c; mem_wa = wa; mem_result = r;
    endtask

    task automatic wb_set(input logic w, input logic [4:0] wa, input logic [N-1:0] d);
        wb_reg_write = w; wb_wa = wa; wb_data = d;
    endtask

    task automatic stall_pulse(input string nm, input logic exp);
        #1 chk(nm, stall_o, exp);
        if (exp && exp_cnt < 15) exp_cnt++;
    endtask

    // Monitor: every presented EX instruction must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && ex_valid) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ex got pc=%h exp=none", ex_pc);
                end else begin
                    e = q.pop_front();
                    chk("ex_opa",  ex_opa,  e.opa);
                    chk("ex_opb",  ex_opb,  e.opb);
                    chk("ex_wa",   64'(ex_wa), 64'(e.wa));
                    chk("ex_pc",   ex_pc,   e.pc);
                    chk("ex_imm",  ex_imm,  e.pc + 64'h1000);
                    chk("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        c_add = '0;  c_add.reg_write = 1'b1; c_add.alu_op = 4'b0010;
        c_add.uses_ra1 = 1'b1; c_add.uses_ra2 = 1'b1;
        c_ldur = '0; c_ldur.reg_write = 1'b1; c_ldur.mem_read = 1'b1;
        c_ldur.mem_to_reg = 1'b1; c_ldur.alu_src = 1'b1; c_ldur.uses_ra1 = 1'b1;

        reset_n = 1'b0; flush_i = 1'b0;
        id_set(1'b1, c_add, 5'd1, 5'd2, 5'd9, 64'h1, 64'h2, 64'h80);
        mem_set(1'b0, '0, 5'd0, '0);
        wb_set(1'b0, 5'd0, '0);
        repeat (3) @(negedge clk);
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl",  64'(ex_ctrl), 0);
        chk("rst_cnt",   stall_cnt, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_opa",   ex_opa, 0);
        chk("rst_pc",    ex_pc, 0);

        // Plain ADD capture
        reset_n = 1'b1;
        id_set(1'b1, c_add, 5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'h100);
        push(64'd5, 64'd7, 5'd3, 64'h100, c_add);
        stall_pulse("add_stall", 1'b0);
        @(negedge clk); id_idle();

        // Load-use
        @(negedge clk);
        id_set(1'b1, c_ldur, 5'd1, 5'd0, 5'd2, 64'h40, 64'h0, 64'h104);
        push(64'h40, 64'h0, 5'd2, 64'h104, c_ldur);
        stall_pulse("lu_stall0", 1'b0);
        @(negedge clk);
        id_set(1'b1, c_add, 5'd2, 5'd3, 5'd5, 64'h11, 64'h22, 64'h108);
        stall_pulse("lu_stall1", 1'b1);
        @(negedge clk);
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl",  64'(ex_ctrl), 0);
        chk("lu_cnt1", stall_cnt, 1);
`ifdef ID_EX_FWD_EN
        wb_set(1'b1, 5'd2, 64'h77);
        stall_pulse("lu_stall2", 1'b0);
        push(64'h77, 64'h22, 5'd5, 64'h108, c_add);
`else
        mem_set(1'b1, c_ldur, 5'd2, 64'h40);
        stall_pulse("lu_stall2", 1'b1);
        @(negedge clk);
        chk("lu_cnt2", stall_cnt, 2);
        mem_set(1'b0, '0, 5'd0, '0);
        id_set(1'b1, c_add, 5'd2, 5'd3, 5'd5, 64'h77, 64'h22, 64'h108);
        stall_pulse("lu_stall3", 1'b0);
        push(64'h77, 64'h22, 5'd5, 64'h108, c_add);
`endif
        @(negedge clk); id_idle(); wb_set(1'b0, 5'd0, '0);
        chk("lu_cnt_final", stall_cnt, 64'(exp_cnt));

        // Writes to XZR never stall
        @(negedge clk);
        id_set(1'b1, c_add, 5'd1, 5'd2, 5'd31, 64'h1, 64'h2, 64'h10C);
        push(64'h1, 64'h2, 5'd31, 64'h10C, c_add);
        stall_pulse("xzr_stall0", 1'b0);
        @(negedge clk);
        id_set(1'b1, c_add, 5'd31, 5'd31, 5'd7, 64'h0, 64'h0, 64'h110);
        mem_set(1'b1, c_add, 5'd31, 64'hCC);
        stall_pulse("xzr_stall1", 1'b0);
        push(64'h0, 64'h0, 5'd7, 64'h110, c_add);
        @(negedge clk); id_idle(); mem_set(1'b0, '0, 5'd0, '0);

`ifdef ID_EX_FWD_EN
        // MEM beats WB; XZR destination never forwards
        @(negedge clk);
        id_set(1'b1, c_add, 5'd4, 5'd31, 5'd6, 64'h1, 64'h2, 64'h114);
        mem_set(1'b1, c_add, 5'd4, 64'hAA);
        wb_set(1'b1, 5'd4, 64'hBB);
        stall_pulse("fwd_stall0", 1'b0);
        push(64'hAA, 64'h2, 5'd6, 64'h114, c_add);
        @(negedge clk);
        id_set(1'b1, c_add, 5'd4, 5'd31, 5'd8, 64'h1, 64'h3, 64'h118);
        mem_set(1'b1, c_add, 5'd31, 64'hCC);
        stall_pulse("fwd_stall1", 1'b0);
        push(64'hBB, 64'h3, 5'd8, 64'h118, c_add);
        @(negedge clk); id_idle(); mem_set(1'b0, '0, 5'd0, '0); wb_set(1'b0, 5'd0, '0);
`endif

        // Flush overrides a load-use stall
        @(negedge clk);
        id_set(1'b1, c_ldur, 5'd1, 5'd0, 5'd2, 64'h50, 64'h0, 64'h120);
        push(64'h50, 64'h0, 5'd2, 64'h120, c_ldur);
        @(negedge clk);
        id_set(1'b1, c_add, 5'd2, 5'd3, 5'd5, 64'h11, 64'h22, 64'h124);
        flush_i = 1'b1;
        stall_pulse("flush_stall", 1'b0);
        @(negedge clk);
        flush_i = 1'b0; id_idle();
        chk("flush_bubble", ex_valid, 0);
        chk("flush_cnt", stall_cnt, 64'(exp_cnt));

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        id_set(1'b1, c_ldur, 5'd1, 5'd0, 5'd2, 64'h60, 64'h0, 64'h130);
        push(64'h60, 64'h0, 5'd2, 64'h130, c_ldur);
        @(negedge clk);
        id_set(1'b1, c_add, 5'd2, 5'd3, 5'd5, 64'h33, 64'h44, 64'h134);
        #1 chk("mid_stall", stall_o, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", ex_valid, 0);
        chk("mid_rst_ctrl",  64'(ex_ctrl), 0);
        chk("mid_rst_pc",    ex_pc, 0);
        chk("mid_rst_stall", stall_o, 0);
        chk("mid_rst_cnt",   stall_cnt, 0);
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        stall_pulse("post_rst_stall", 1'b0);
        push(64'h33, 64'h44, 5'd5, 64'h134, c_add);
        @(negedge clk); id_idle();
        chk("post_rst_cnt", stall_cnt, 0);

        // Counter saturates at all-ones
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            id_set(1'b1, c_ldur, 5'd1, 5'd0, 5'd2, 64'h70, 64'h0, 64'h200);
            push(64'h70, 64'h0, 5'd2, 64'h200, c_ldur);
            @(negedge clk);
            id_set(1'b1, c_add, 5'd2, 5'd3, 5'd5, 64'h1, 64'h2, 64'h204);
            stall_pulse("sat_stall", 1'b1);
            @(negedge clk); id_idle();
            chk("sat_cnt", stall_cnt, (i < 15) ? 64'(i) : 64'hF);
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
